// File: rtl/mips_bus_pkg.sv
// Shared definitions for the MIPS core-to-pad pin bus bridge.
// Holds the transaction state encoding and the command-beat layout helper.
package mips_bus_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        WACK,
        RDATA,
        DONE
    } state_e;

    // The write/read flag occupies the top lane bit of the command beat.
    function automatic int cmd_we_pos(input int bus_w);
        return bus_w - 1;
    endfunction

endpackage

// File: rtl/mips_bus_timeout.sv
// Ack-wait watchdog: counts cycles without an ack and flags expiry when TIMEOUT is reached.
// With TIMEOUT=0 the watchdog is removed and never expires.
module mips_bus_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic tick,
    output logic expire
);

    generate
        if (TIMEOUT == 0) begin : g_off
            assign expire = 1'b0;
        end else begin : g_on
            localparam int CW = $clog2(TIMEOUT + 1);
            localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            always_comb begin
                cnt_d = cnt_q;
                if (clear)
                    cnt_d = '0;
                else if (tick)
                    cnt_d = cnt_q + CW'(1);
            end

            always_ff @(posedge clk) begin
                if (rst)
                    cnt_q <= '0;
                else
                    cnt_q <= cnt_d;
            end

            // Fires on the tick that would bring the count up to TIMEOUT.
            assign expire = tick && !clear && (cnt_q == LAST);
        end
    endgenerate

endmodule

// File: rtl/mips_pin_bus_bridge.sv
// Core-to-pad bridge: serialises one load/store request at a time onto a narrow byte-lane
// pin bus with command framing, bus turnaround, per-beat ack and a timeout error response.
module mips_pin_bus_bridge
    import mips_bus_pkg::*;
#(
    parameter int ADDR_W  = 16,
    parameter int DATA_W  = 32,
    parameter int BUS_W   = 8,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    output logic              rsp_err,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [BUS_W-1:0]  bus_out,
    output logic [BUS_W-1:0]  bus_oe,
    input  logic [BUS_W-1:0]  bus_in,
    output logic              bus_strb,
    output logic              bus_frame,
    input  logic              bus_ack
);

    localparam int NA        = ADDR_W / BUS_W;
    localparam int ND        = DATA_W / BUS_W;
    localparam int BEATS_MAX = (NA > ND) ? NA : ND;
    localparam int CNT_W     = (BEATS_MAX > 1) ? $clog2(BEATS_MAX) : 1;
    localparam int WE_BIT    = cmd_we_pos(BUS_W);
    localparam logic [CNT_W-1:0] NA_LAST = CNT_W'(NA - 1);
    localparam logic [CNT_W-1:0] ND_LAST = CNT_W'(ND - 1);

    state_e              state_q, state_d;
    logic                we_q, we_d;
    logic                err_q, err_d;
    logic [CNT_W-1:0]    beat_q, beat_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [DATA_W-1:0]   rdsh_q, rdsh_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;

    logic                waiting;
    logic                tmo_expire;
    logic [DATA_W+BUS_W-1:0] rd_cat;
    logic [DATA_W-1:0]   rd_next;

    // Inbound beats enter at the top and drift down, so the first beat ends up in lane 0.
    assign rd_cat  = {bus_in, rdsh_q};
    assign rd_next = rd_cat[DATA_W+BUS_W-1:BUS_W];
    assign waiting = (state_q == WACK) || (state_q == RDATA);

    mips_bus_timeout #(
        .TIMEOUT(TIMEOUT)
    ) u_timeout (
        .clk   (clk),
        .rst   (rst),
        .clear (!waiting || bus_ack),
        .tick  (waiting && !bus_ack),
        .expire(tmo_expire)
    );

    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        err_d   = err_q;
        beat_d  = beat_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdsh_d  = rdsh_q;
        rdata_d = rdata_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    rdsh_d  = '0;
                    beat_d  = '0;
                    state_d = CMD;
                end
            end
            CMD: state_d = ADDR;
            ADDR: begin
                addr_d = addr_q >> BUS_W;
                if (beat_q == NA_LAST) begin
                    beat_d  = '0;
                    state_d = we_q ? WDATA : RDATA;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            WDATA: begin
                wdata_d = wdata_q >> BUS_W;
                if (beat_q == ND_LAST) begin
                    beat_d  = '0;
                    state_d = WACK;
                end else begin
                    beat_d = beat_q + CNT_W'(1);
                end
            end
            WACK: begin
                if (bus_ack || tmo_expire) begin
                    err_d   = !bus_ack;
                    rdata_d = '0;
                    state_d = DONE;
                end
            end
            RDATA: begin
                if (bus_ack) begin
                    rdsh_d = rd_next;
                    if (beat_q == ND_LAST) begin
                        rdata_d = rd_next;
                        err_d   = 1'b0;
                        state_d = DONE;
                    end else begin
                        beat_d = beat_q + CNT_W'(1);
                    end
                end else if (tmo_expire) begin
                    rdata_d = '0;
                    err_d   = 1'b1;
                    state_d = DONE;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            beat_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            err_q   <= err_d;
            beat_q  <= beat_d;
            rdata_q <= rdata_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_q  <= addr_d;
        wdata_q <= wdata_d;
        rdsh_q  <= rdsh_d;
    end

    always_comb begin
        bus_out   = '0;
        bus_oe    = '0;
        bus_strb  = 1'b0;
        bus_frame = 1'b0;
        case (state_q)
            CMD: begin
                bus_out[WE_BIT] = we_q;
                bus_oe          = '1;
                bus_strb        = 1'b1;
                bus_frame       = 1'b1;
            end
            ADDR: begin
                bus_out   = addr_q[BUS_W-1:0];
                bus_oe    = '1;
                bus_strb  = 1'b1;
                bus_frame = 1'b1;
            end
            WDATA: begin
                bus_out   = wdata_q[BUS_W-1:0];
                bus_oe    = '1;
                bus_strb  = 1'b1;
                bus_frame = 1'b1;
            end
            WACK, RDATA: bus_frame = 1'b1;
            default: ;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == DONE);
    assign rsp_err   = err_q;
    assign rsp_rdata = rdata_q;

endmodule
